mod_mul_arbiter: RTL and testbench
==================================

Name: mod_mul_arbiter

Overview:
- Shares one pipelined Mod_mul instance (12-bit operands, q = 3329, valid_in/valid_out handshake) between two requesters, e.g. NTT butterfly (port 0) and pointwise multiply (port 1).
- Arbitrates round-robin, reduces operands into [0, Q), issues one product per cycle and tracks each in-flight product's owner in a tag pipeline matched to the multiplier latency.
- Returns each result to its originating requester.
- Sits between the polynomial-arithmetic control FSMs and the Mod_mul datapath. It drives Mod_mul's ports but does not instantiate it.

Parameters:
- W, 12, operand/result width.
- Q, 3329, modulus used for operand pre-reduction.
- MUL_LAT, 3, cycles from Mod_mul valid_in sampled to valid_out asserted. Must equal the attached Mod_mul latency.

Ports:
- clk  input  1  rising-edge clock
- r  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has an operand pair
- req0_ready  output  1  requester 0 accepted this cycle (combinational)
- req0_a, req0_b  input  W  requester 0 operands
- req1_valid  input  1  requester 1 has an operand pair
- req1_ready  output  1  requester 1 accepted this cycle (combinational)
- req1_a, req1_b  input  W  requester 1 operands
- rsp0_valid  output  1  result for requester 0, one-cycle pulse
- rsp1_valid  output  1  result for requester 1, one-cycle pulse
- rsp_data  output  W  result value, shared by both requesters
- mul_valid_in  output  1  to Mod_mul valid_in
- mul_a, mul_b  output  W  to Mod_mul A, B
- mul_valid_out  input  1  from Mod_mul valid_out
- mul_out  input  W  from Mod_mul OUT
- busy  output  1  any product in flight or response pending
- tag_err  output  1  sticky; valid_out/tag-pipe mismatch detected

Behaviour:
- Reset (r = 0, asynchronous):
  - Every output register clears: mul_valid_in, mul_a, mul_b, rsp0_valid, rsp1_valid, rsp_data, tag_err = 0.
  - Tag pipe clears. Round-robin pointer is set so requester 0 wins first.
  - Ready outputs are 0 while r = 0.
- Reset mid-operation discards all in-flight products; no rsp pulse is produced for them.
- Arbitration (combinational, same cycle):
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted most recently is granted.
  - Neither valid: no grant.
  - reqN_ready = grant to N. The pointer updates only on an accepted transfer (valid & ready).
  - No backpressure from the multiplier: one accept is possible every cycle.
- Operand pre-reduction: each operand x with x >= Q is replaced by x - Q before issue. The result is always < Q for W = 12.
- Issue (accept in cycle t):
  - At edge t+1, mul_valid_in = 1 and mul_a / mul_b take the reduced operands.
  - A tag entry {valid = 1, owner} enters stage 0 of an MUL_LAT-deep shift register.
  - Cycles with no accept push {0, x} into the tag pipe.
- Return:
  - When mul_valid_out = 1 and the tag-pipe head is valid, register rsp_data = mul_out and pulse rspN_valid for owner N.
  - Response appears at edge t+2+MUL_LAT. Total accept-to-response latency is MUL_LAT+2 cycles.
- Tag mismatch: if mul_valid_out differs from the head valid bit, set tag_err (sticky until reset) and suppress the response.
- Throughput: one product per cycle sustained. Interleaved requesters get per-cycle alternation when both stay valid.
- busy: OR of mul_valid_in, all tag-pipe valid bits, rsp0_valid and rsp1_valid.
- Ordering: responses return in acceptance order, both globally and per requester.

Test Plan:
- Reset then single request: req0 (1000, 3) accepted at cycle t -> rsp0_valid pulses at t+5 with rsp_data = 3000; rsp1_valid stays 0.
- Back-to-back on port 0: (1000, 1000), (3320, 3320), (3328, 3328) on consecutive cycles -> rsp0 pulses on 3 consecutive cycles with 1300, 81, 1.
- Contention: both requesters valid for 4 cycles, req0 (2, 3) and req1 (5, 7) -> grants alternate 0, 1, 0, 1; responses alternate 6, 35, 6, 35 on rsp0 / rsp1.
- Pre-reduction: req1 (4000, 1) -> mul_a = 671; rsp1 data = 671. Also req1 (3329, 5) -> mul_a = 0; data = 0.
- Reset mid-flight: accept 2 requests, drive r = 0 two cycles later -> all outputs 0 immediately; no rsp pulse after release; busy = 0.
- Fault injection: force mul_valid_out = 1 with an empty tag pipe -> tag_err = 1 and stays 1; no rsp pulse.

Source files
------------

// File: rtl/mod_mul_arbiter.sv
// Round-robin front end that shares one pipelined Mod_mul between two requesters.
// Each issued product carries an owner tag so its result returns to the right port.
module mod_mul_arbiter #(
  parameter int unsigned W       = 12,
  parameter int unsigned Q       = 3329,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         r,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp_data,
  output logic         mul_valid_in,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  input  logic         mul_valid_out,
  input  logic [W-1:0] mul_out,
  output logic         busy,
  output logic         tag_err
);

  localparam logic [W-1:0] QW = W'(Q);

  function automatic logic [W-1:0] reduce(input logic [W-1:0] x);
    return (x >= QW) ? x - QW : x;
  endfunction

  logic         last_q, last_d;
  logic         mul_valid_in_q, mul_valid_in_d;
  logic [W-1:0] mul_a_q, mul_a_d;
  logic [W-1:0] mul_b_q, mul_b_d;
  logic [MUL_LAT:0] tag_v_q, tag_v_d;
  logic [MUL_LAT:0] tag_o_q, tag_o_d;
  logic         rsp0_q, rsp0_d;
  logic         rsp1_q, rsp1_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic         tag_err_q, tag_err_d;

  logic gnt0, gnt1, acc, owner, head_v, head_o;

  // last_q holds the most recent grant; a tie goes to the other requester.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (last_q) gnt0 = 1'b1;
      else        gnt1 = 1'b1;
    end else if (req0_valid) begin
      gnt0 = 1'b1;
    end else if (req1_valid) begin
      gnt1 = 1'b1;
    end
    req0_ready = gnt0 & r;
    req1_ready = gnt1 & r;
    acc        = req0_ready | req1_ready;
    owner      = req1_ready;
  end

  // Tag stage 0 is aligned with mul_valid_in, so the head lines up with mul_valid_out.
  assign head_v = tag_v_q[MUL_LAT];
  assign head_o = tag_o_q[MUL_LAT];

  always_comb begin
    last_d         = acc ? owner : last_q;
    mul_valid_in_d = acc;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    if (acc) begin
      mul_a_d = reduce(owner ? req1_a : req0_a);
      mul_b_d = reduce(owner ? req1_b : req0_b);
    end
    tag_v_d    = {tag_v_q[MUL_LAT-1:0], acc};
    tag_o_d    = {tag_o_q[MUL_LAT-1:0], owner};
    rsp0_d     = 1'b0;
    rsp1_d     = 1'b0;
    rsp_data_d = rsp_data_q;
    tag_err_d  = tag_err_q;
    if (mul_valid_out != head_v) begin
      tag_err_d = 1'b1;
    end else if (head_v) begin
      rsp_data_d = mul_out;
      rsp0_d     = ~head_o;
      rsp1_d     = head_o;
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      last_q         <= 1'b1;
      mul_valid_in_q <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      tag_v_q        <= '0;
      tag_o_q        <= '0;
      rsp0_q         <= 1'b0;
      rsp1_q         <= 1'b0;
      rsp_data_q     <= '0;
      tag_err_q      <= 1'b0;
    end else begin
      last_q         <= last_d;
      mul_valid_in_q <= mul_valid_in_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      tag_v_q        <= tag_v_d;
      tag_o_q        <= tag_o_d;
      rsp0_q         <= rsp0_d;
      rsp1_q         <= rsp1_d;
      rsp_data_q     <= rsp_data_d;
      tag_err_q      <= tag_err_d;
    end
  end

  assign mul_valid_in = mul_valid_in_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign rsp0_valid   = rsp0_q;
  assign rsp1_valid   = rsp1_q;
  assign rsp_data     = rsp_data_q;
  assign tag_err      = tag_err_q;
  assign busy         = mul_valid_in_q | (|tag_v_q) | rsp0_q | rsp1_q;

endmodule

// File: tb/tb_mod_mul_arbiter.sv
// Directed bench for mod_mul_arbiter with a 3-stage behavioural Mod_mul model.
module tb_mod_mul_arbiter;

  logic        clk = 1'b0;
  logic        r = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [11:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic [11:0] rsp_data;
  logic        mul_valid_in;
  logic [11:0] mul_a, mul_b;
  logic        mul_valid_out;
  logic [11:0] mul_out;
  logic        busy, tag_err;
  logic        inj = 1'b0;

  int checks = 0;
  int failures = 0;
  logic saw_rsp;

  always #5 clk = ~clk;

  mod_mul_arbiter dut (
    .clk(clk), .r(r),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .mul_valid_in(mul_valid_in), .mul_a(mul_a), .mul_b(mul_b),
    .mul_valid_out(mul_valid_out), .mul_out(mul_out),
    .busy(busy), .tag_err(tag_err)
  );

  // Mod_mul stand-in: three register stages from valid_in to valid_out.
  logic [2:0]  mv;
  logic [11:0] p1, p2, p3;
  logic [11:0] prod;
  assign prod          = 12'((32'(mul_a) * 32'(mul_b)) % 32'd3329);
  assign mul_valid_out = mv[2] | inj;
  assign mul_out       = p3;

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      mv <= '0;
      p1 <= '0;
      p2 <= '0;
      p3 <= '0;
    end else begin
      mv <= {mv[1:0], mul_valid_in};
      p1 <= prod;
      p2 <= p1;
      p3 <= p2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rsp_chk(input string tag, input logic e0, input logic e1, input int d);
    chk({tag, "_rsp0"}, 32'(rsp0_valid), 32'(e0));
    chk({tag, "_rsp1"}, 32'(rsp1_valid), 32'(e1));
    if (e0 || e1) chk({tag, "_data"}, 32'(rsp_data), 32'(d));
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_mvi", 32'(mul_valid_in), 0);
    chk("rst_mula", 32'(mul_a), 0);
    chk("rst_rsp", 32'({rsp0_valid, rsp1_valid}), 0);
    chk("rst_data", 32'(rsp_data), 0);
    chk("rst_err", 32'(tag_err), 0);
    chk("rst_busy", 32'(busy), 0);
    req0_valid = 1'b1;
    #1;
    chk("rst_ready0", 32'(req0_ready), 0);
    req0_valid = 1'b0;
    tick();
    r = 1'b1;
    tick();

    // Single request: accept at t, response at t+5
    req0_valid = 1'b1; req0_a = 12'd1000; req0_b = 12'd3;
    #1;
    chk("s_ready0", 32'(req0_ready), 1);
    chk("s_ready1", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0;
    chk("s_mvi", 32'(mul_valid_in), 1);
    chk("s_mula", 32'(mul_a), 1000);
    chk("s_mulb", 32'(mul_b), 3);
    chk("s_busy", 32'(busy), 1);
    tick(); rsp_chk("s_t2", 0, 0, 0);
    tick(); rsp_chk("s_t3", 0, 0, 0);
    tick(); rsp_chk("s_t4", 0, 0, 0);
    tick(); rsp_chk("s_t5", 1, 0, 3000);
    tick(); rsp_chk("s_t6", 0, 0, 0);
    chk("s_idle", 32'(busy), 0);

    // Back-to-back on port 0
    req0_valid = 1'b1; req0_a = 12'd1000; req0_b = 12'd1000;
    tick();
    req0_a = 12'd3320; req0_b = 12'd3320;
    tick();
    req0_a = 12'd3328; req0_b = 12'd3328;
    tick();
    req0_valid = 1'b0;
    tick();
    tick(); rsp_chk("b_0", 1, 0, 1300);
    tick(); rsp_chk("b_1", 1, 0, 81);
    tick(); rsp_chk("b_2", 1, 0, 1);
    tick(); rsp_chk("b_3", 0, 0, 0);

    // Pre-reduction on port 1
    req1_valid = 1'b1; req1_a = 12'd4000; req1_b = 12'd1;
    #1;
    chk("p_ready1", 32'(req1_ready), 1);
    chk("p_ready0", 32'(req0_ready), 0);
    tick();
    chk("p_mula0", 32'(mul_a), 671);
    chk("p_mulb0", 32'(mul_b), 1);
    req1_a = 12'd3329; req1_b = 12'd5;
    tick();
    req1_valid = 1'b0;
    chk("p_mula1", 32'(mul_a), 0);
    chk("p_mulb1", 32'(mul_b), 5);
    tick();
    tick();
    tick(); rsp_chk("p_r0", 0, 1, 671);
    tick(); rsp_chk("p_r1", 0, 1, 0);
    tick(); rsp_chk("p_r2", 0, 0, 0);

    // Contention: both valid for 4 cycles, last grant was port 1
    req0_valid = 1'b1; req0_a = 12'd2; req0_b = 12'd3;
    req1_valid = 1'b1; req1_a = 12'd5; req1_b = 12'd7;
    #1;
    chk("c_g0", 32'({req0_ready, req1_ready}), 2);
    tick();
    chk("c_g1", 32'({req0_ready, req1_ready}), 1);
    chk("c_mula", 32'(mul_a), 2);
    tick();
    chk("c_g2", 32'({req0_ready, req1_ready}), 2);
    chk("c_mulb", 32'(mul_b), 7);
    tick();
    chk("c_g3", 32'({req0_ready, req1_ready}), 1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); rsp_chk("c_r0", 1, 0, 6);
    tick(); rsp_chk("c_r1", 0, 1, 35);
    tick(); rsp_chk("c_r2", 1, 0, 6);
    tick(); rsp_chk("c_r3", 0, 1, 35);
    tick(); rsp_chk("c_r4", 0, 0, 0);
    chk("c_idle", 32'(busy), 0);

    // Reset mid-flight
    req0_valid = 1'b1; req0_a = 12'd10; req0_b = 12'd10;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 12'd20; req1_b = 12'd20;
    tick();
    req1_valid = 1'b0;
    tick();
    r = 1'b0;
    #1;
    chk("m_mvi", 32'(mul_valid_in), 0);
    chk("m_mula", 32'(mul_a), 0);
    chk("m_busy", 32'(busy), 0);
    chk("m_data", 32'(rsp_data), 0);
    req1_valid = 1'b1;
    #1;
    chk("m_ready1", 32'(req1_ready), 0);
    req1_valid = 1'b0;
    tick();
    r = 1'b1;
    saw_rsp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      saw_rsp = saw_rsp | rsp0_valid | rsp1_valid;
    end
    chk("m_norsp", 32'(saw_rsp), 0);
    chk("m_busy2", 32'(busy), 0);
    chk("m_err", 32'(tag_err), 0);

    // Spurious valid_out with an empty tag pipe
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("f_err", 32'(tag_err), 1);
    chk("f_rsp", 32'({rsp0_valid, rsp1_valid}), 0);
    saw_rsp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      saw_rsp = saw_rsp | rsp0_valid | rsp1_valid;
    end
    chk("f_sticky", 32'(tag_err), 1);
    chk("f_norsp", 32'(saw_rsp), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
